// File: rtl/mult_shift_add_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//   state_e        : controller state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH  : default operand width in bits
//   DEFAULT_CNT_W  : default iteration counter width (2**CNT_W must exceed WIDTH)
package mult_shift_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = 6;

endpackage

// File: rtl/mult_shift_add_if.sv
// Request/result bundle of the shift-and-add multiplier.
//   start   : request to begin, honoured only while the unit is idle
//   a, b    : unsigned multiplicand / multiplier
//   busy    : operation in flight (accept through done pulse)
//   done    : one-cycle pulse, product valid
//   product : 2*WIDTH-bit result, held until the next operation completes
// master = requester side, slave = multiplier side.
interface mult_shift_add_if
    import mult_shift_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/mult_shift_add_rca.sv
// WIDTH-bit combinational ripple-carry adder.
//   a, b : addends
//   cin  : carry into bit 0
//   sum  : WIDTH-bit sum
//   cout : carry out of bit WIDTH-1
module rca_adder
    import mult_shift_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic carry;

    always_comb begin
        sum   = '0;
        carry = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/mult_shift_add.sv
// Iterative unsigned WIDTH x WIDTH shift-and-add multiplier.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; discards any operation in flight
//   bus   : request/result bundle (slave side), see mult_shift_add_if
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; product holds last result
// RUN   | one add-and-shift step per cycle, WIDTH steps
// DONE  | product loaded; raises the done pulse and returns to IDLE
module mult_shift_add
    import mult_shift_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    mult_shift_add_if.slave   bus
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     add_sum;
    logic                 add_cout;

    // The multiplier's LSB (shifted down each step) selects whether the
    // multiplicand is added this iteration.
    assign addend = acc_lo_q[0] ? mcand_q : '0;

    rca_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (acc_hi_q),
        .b    (addend),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        product_d = product_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = bus.start;
                if (bus.start) begin
                    mcand_d  = bus.a;
                    acc_hi_d = '0;
                    acc_lo_d = bus.b;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // {cout, sum, acc_lo} >> 1: the carry-out lands in the MSB of
                // acc_hi so no product bit is lost.
                acc_hi_d = {add_cout, add_sum[WIDTH-1:1]};
                acc_lo_d = {add_sum[0], acc_lo_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d   = DONE;
                    product_d = {acc_hi_d, acc_lo_d};
                end
            end
            DONE: begin
                // busy stays high through the done pulse; cleared in IDLE.
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule

// File: tb/tb_mult_shift_add.sv
module tb_mult_shift_add;

    localparam int W = 32;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [2*W-1:0] last_product;

    mult_shift_add_if #(.WIDTH(W)) bus ();

    mult_shift_add #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: product is plain arithmetic a*b; done arrives in the
    // (WIDTH+2)th cycle after the accepting edge; busy spans those cycles;
    // product is unchanged for the first WIDTH cycles.
    task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                         input int poke_at, input string tag);
        logic [2*W-1:0] expv;
        logic [2*W-1:0] done_prod;
        int ndone, done_j, busy_bad, hold_bad;
        expv = (2*W)'(op_a) * (2*W)'(op_b);
        ndone = 0; done_j = -1; busy_bad = 0; hold_bad = 0; done_prod = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = op_a; bus.b = op_b;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
        for (int j = 0; j <= W + 2; j++) begin
            @(negedge clk);
            if (bus.busy !== 1'(j <= W + 1)) busy_bad++;
            if (bus.done === 1'b1) begin
                ndone++; done_j = j; done_prod = bus.product;
            end else if (bus.done !== 1'b0) begin
                busy_bad++;
            end
            if (j < W && bus.product !== last_product) hold_bad++;
            if (j == poke_at) begin
                bus.start = 1'b1; bus.a = 100; bus.b = 100;
            end else if (j == poke_at + 1) begin
                bus.start = 1'b0;
            end
        end
        chk({tag, " done_count"}, (2*W)'(ndone), (2*W)'(1));
        chk({tag, " done_cycle"}, (2*W)'(done_j), (2*W)'(W + 1));
        chk({tag, " product_at_done"}, done_prod, expv);
        chk({tag, " busy_pattern_errs"}, (2*W)'(busy_bad), '0);
        chk({tag, " product_hold_errs"}, (2*W)'(hold_bad), '0);
        chk({tag, " product_after"}, bus.product, expv);
        last_product = expv;
    endtask

    initial begin
        int ndone, nbusy, done_times[$];
        logic [2*W-1:0] done_vals[$];
        checks = 0; errors = 0; last_product = '0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        reset = 1'b1;
        #1;
        chk("reset busy", (2*W)'(bus.busy), '0);
        chk("reset done", (2*W)'(bus.done), '0);
        chk("reset product", bus.product, '0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;

        do_op(32'd3, 32'd5, -1, "basic");
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "max");
        chk("max literal", last_product, 64'hFFFF_FFFE_0000_0001);
        do_op(32'h8000_0000, 32'd2, -1, "carry");
        chk("carry literal", last_product, 64'h0000_0001_0000_0000);
        do_op(32'd0, 32'h1234_5678, -1, "zero_a");
        do_op(32'h1234_5678, 32'd1, -1, "one_b");
        do_op(32'd7, 32'd9, 10, "ignored_start");
        chk("ignored_start literal", last_product, 64'd63);

        // Reset mid-operation, asserted away from any clock edge.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'd6; bus.b = 32'd7;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (12) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset busy", (2*W)'(bus.busy), '0);
        chk("midreset done", (2*W)'(bus.done), '0);
        chk("midreset product", bus.product, '0);
        last_product = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        ndone = 0; nbusy = 0;
        for (int j = 0; j < W + 4; j++) begin
            @(negedge clk);
            if (bus.done !== 1'b0) ndone++;
            if (bus.busy !== 1'b0) nbusy++;
        end
        chk("postreset done_count", (2*W)'(ndone), '0);
        chk("postreset busy_count", (2*W)'(nbusy), '0);
        do_op(32'd6, 32'd7, -1, "after_reset");

        // Back-to-back with start held high.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'd10; bus.b = 32'd20;
        @(posedge clk); #1;
        bus.a = 32'd11; bus.b = 32'd13;
        for (int j = 0; j <= 2 * W + 6; j++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                done_times.push_back(j);
                done_vals.push_back(bus.product);
            end
            if (j == W + 2) bus.start = 1'b0;
        end
        chk("b2b done_count", (2*W)'(done_times.size()), (2*W)'(2));
        if (done_times.size() == 2) begin
            chk("b2b first", done_vals[0], 64'd200);
            chk("b2b second", done_vals[1], 64'd143);
            chk("b2b spacing", (2*W)'(done_times[1] - done_times[0]), (2*W)'(W + 2));
        end
        last_product = 64'd143;

        // Randomized operands against plain arithmetic.
        for (int k = 0; k < 6; k++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            rb = (k % 2 == 0) ? W'($urandom) : W'($urandom_range(0, 255));
            do_op(ra, rb, -1, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
